// File: rtl/lobinho_pkg.sv
// Shared game types: role codes, LFSR taps, dealer state encoding and the
// Galois LFSR step used by every LFSR in the game controller.
package lobinho_pkg;

  typedef logic [1:0] role_t;

  localparam role_t ROLE_VILLAGER = 2'b00;
  localparam role_t ROLE_WOLF     = 2'b01;
  localparam role_t ROLE_DOCTOR   = 2'b10;
  localparam role_t ROLE_SEER     = 2'b11;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_PROBE,
    ST_DONE
  } dealer_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with synchronous seed load; a zero seed
// is remapped to 0x0001 so the register can never lock up.
module lfsr16
  import lobinho_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_d, state_q;

  always_comb begin
    state_d = lfsr_step(state_q);
    if (load) state_d = (seed == 16'h0000) ? 16'h0001 : seed;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= 16'h0001;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/role_dealer.sv
// Deals a random role vector (wolves, doctors, optional seers) using an LFSR
// draw followed by bounded linear probing. Seers enabled by ROLE_DEALER_SEER_EN.
module role_dealer
  import lobinho_pkg::*;
#(
  parameter int N_PLAYERS = 5,
  parameter int N_WOLVES  = 1,
  parameter int N_DOCTORS = 1,
  parameter int LFSR_W    = 16
`ifdef ROLE_DEALER_SEER_EN
  , parameter int N_SEERS = 1
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   roles_valid,
  output logic [2*N_PLAYERS-1:0] roles
);

`ifdef ROLE_DEALER_SEER_EN
  localparam int NS = N_SEERS;
`else
  localparam int NS = 0;
`endif
  localparam int IDX_W = $clog2(N_PLAYERS);
  localparam int CNT_W = $clog2(N_PLAYERS + 1);
  localparam logic [IDX_W:0] NP   = (IDX_W+1)'(N_PLAYERS);
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(N_PLAYERS - 1);

  if (N_PLAYERS < 2 || N_PLAYERS > 16 || N_WOLVES < 1 || N_WOLVES > N_PLAYERS - 1 ||
      N_DOCTORS < 0 || NS < 0 || N_WOLVES + N_DOCTORS + NS > N_PLAYERS ||
      LFSR_W != 16) begin : g_bad_params
    $error("role_dealer: illegal parameter combination");
  end

  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (seed_load),
    .seed  (seed_in),
    .state (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:IDX_W];

  dealer_state_t                 state_d, state_q;
  logic [IDX_W-1:0]              cand_d, cand_q;
  role_t                         kind_d, kind_q;
  logic [CNT_W-1:0]              rem_d, rem_q;
  logic [N_PLAYERS-1:0]          occ_d, occ_q;
  // ascending packed range puts player 0 in the most significant field
  logic [0:N_PLAYERS-1][1:0]     work_d, work_q;
  logic [0:N_PLAYERS-1][1:0]     roles_d, roles_q;
  logic                          busy_d, busy_q;
  logic                          valid_d, valid_q;
  logic [IDX_W:0]                draw_ext;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    kind_d   = kind_q;
    rem_d    = rem_q;
    occ_d    = occ_q;
    work_d   = work_q;
    roles_d  = roles_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    draw_ext = {1'b0, lfsr[IDX_W-1:0]};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        work_d  = '0;
        occ_d   = '0;
        kind_d  = ROLE_WOLF;
        rem_d   = CNT_W'(N_WOLVES);
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // one conditional subtract folds the draw into range (slightly biased)
        cand_d  = (draw_ext >= NP) ? IDX_W'(draw_ext - NP) : draw_ext[IDX_W-1:0];
        state_d = ST_PROBE;
      end
      ST_PROBE: begin
        if (occ_q[cand_q]) begin
          cand_d = ({1'b0, cand_q} == LAST) ? '0 : cand_q + 1'b1;
        end else begin
          work_d[cand_q] = kind_q;
          occ_d[cand_q]  = 1'b1;
          state_d        = ST_DRAW;
          if (rem_q != CNT_W'(1)) begin
            rem_d = rem_q - 1'b1;
          end else if (kind_q == ROLE_WOLF && N_DOCTORS > 0) begin
            kind_d = ROLE_DOCTOR;
            rem_d  = CNT_W'(N_DOCTORS);
          end
`ifdef ROLE_DEALER_SEER_EN
          else if (kind_q != ROLE_SEER && NS > 0) begin
            kind_d = ROLE_SEER;
            rem_d  = CNT_W'(NS);
          end
`endif
          else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        roles_d = work_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      kind_q  <= ROLE_WOLF;
      rem_q   <= '0;
      occ_q   <= '0;
      work_q  <= '0;
      roles_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      kind_q  <= kind_d;
      rem_q   <= rem_d;
      occ_q   <= occ_d;
      work_q  <= work_d;
      roles_q <= roles_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign roles_valid = valid_q;
  assign roles       = roles_q;

endmodule

// File: tb/tb_role_dealer.sv
// Bench for role_dealer: default 5-player instance plus a 2-player instance
// sharing one stimulus stream, checked against a behavioural deal model.
module tb_role_dealer;

`ifdef ROLE_DEALER_SEER_EN
  localparam int NS1 = 1;
`else
  localparam int NS1 = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        seed_load = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic        busy1, valid1, busy2, valid2;
  logic [9:0]  roles1;
  logic [3:0]  roles2;

  int tests = 0;
  int fails = 0;

  role_dealer u_dut1 (
    .clock(clock), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .busy(busy1), .roles_valid(valid1), .roles(roles1)
  );

  role_dealer #(.N_PLAYERS(2), .N_WOLVES(1), .N_DOCTORS(1)
`ifdef ROLE_DEALER_SEER_EN
    , .N_SEERS(0)
`endif
  ) u_dut2 (
    .clock(clock), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .busy(busy2), .roles_valid(valid2), .roles(roles2)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference LFSR: reset to 1, load (zero -> 1) wins, otherwise step each edge
  logic [15:0] m_lfsr;
  always @(posedge clock or posedge reset) begin
    if (reset)          m_lfsr <= 16'h0001;
    else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'h0001 : seed_in;
    else                m_lfsr <= adv(m_lfsr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // lc is the LFSR value during the cycle after the accepting edge; returns
  // the packed vector and the edge count from acceptance to roles_valid.
  function automatic void model(input int n, input int nw, input int nd, input int ns,
                                input logic [15:0] lc, output logic [31:0] r, output int lat);
    logic [15:0] l;
    bit occ[16];
    int c, code;
    l = lc;
    r = '0;
    lat = 1;
    for (int i = 0; i < 16; i++) occ[i] = 0;
    for (int k = 0; k < nw + nd + ns; k++) begin
      code = (k < nw) ? 1 : (k < nw + nd) ? 2 : 3;
      l = adv(l);
      c = int'(l) % (1 << $clog2(n));
      if (c >= n) c -= n;
      lat++;
      l = adv(l);
      while (occ[c]) begin
        c = (c + 1) % n;
        l = adv(l);
        lat++;
      end
      lat++;
      occ[c] = 1;
      r[2*(n-1-c) +: 2] = code[1:0];
    end
    lat++;
  endfunction

  logic [31:0] e1, e2;
  int          el1, el2, lat1, lat2;
  logic [9:0]  r1_last;
  logic [3:0]  r2_last;

  task automatic deal(input bit ld, input logic [15:0] sd, input bit pulse_mid);
    logic [15:0] lc;
    logic [9:0]  old1;
    logic [3:0]  old2;
    bit d1, d2;
    int n;
    @(negedge clock);
    start = 1'b1; seed_load = ld; seed_in = sd;
    old1 = roles1; old2 = roles2;
    @(posedge clock); #1;
    start = 1'b0; seed_load = 1'b0;
    lc = m_lfsr;
    model(5, 1, 1, NS1, lc, e1, el1);
    model(2, 1, 1, 0, lc, e2, el2);
    chk("busy_on_accept", {busy1, busy2}, 2'b11);
    chk("valid_drop", {valid1, valid2}, 2'b00);
    chk("roles_hold", {old1, old2}, {roles1, roles2});
    d1 = 0; d2 = 0; n = 0; lat1 = -1; lat2 = -1;
    while (!(d1 && d2) && n < 60) begin
      @(posedge clock); #1;
      n++;
      start = pulse_mid && (n == 2);
      if (!d1 && valid1) begin d1 = 1; lat1 = n; chk("busy_off1", busy1, 0); end
      if (!d2 && valid2) begin d2 = 1; lat2 = n; chk("busy_off2", busy2, 0); end
    end
    start = 1'b0;
    if (!(d1 && d2)) begin
      tests++; fails++;
      $display("FAIL deal_timeout busy1=%0b busy2=%0b required_done", busy1, busy2);
    end
    chk("roles1", roles1, e1[9:0]);
    chk("lat1", lat1, el1);
    chk("roles2", roles2, e2[3:0]);
    chk("lat2", lat2, el2);
    r1_last = roles1;
    r2_last = roles2;
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  roles2;
    int          lat2;
  } vec_t;

  vec_t        tbl[5];
  logic [9:0]  same_a, same_b;
  bit          seen[5][5];
  int          cnt[4];
  int          wp, dp, covered, max_lat2;
  bit          retry_seen;
  logic [1:0]  f;

  initial begin
    // N=2 deals with seed loaded on the start edge: wolf at seed[1],
    // doctor draws seed[3], one probe retry when they coincide.
    tbl[0] = '{16'h0000, 4'b0110, 7};
    tbl[1] = '{16'h0002, 4'b1001, 6};
    tbl[2] = '{16'h0008, 4'b0110, 6};
    tbl[3] = '{16'h000A, 4'b1001, 7};
    tbl[4] = '{16'h0001, 4'b0110, 7};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {busy1, busy2}, 0);
    chk("rst_valid", {valid1, valid2}, 0);
    chk("rst_roles", {roles1, roles2}, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_busy", {busy1, busy2}, 0);
    chk("idle_valid", {valid1, valid2}, 0);
    chk("idle_roles", {roles1, roles2}, 0);

    for (int i = 0; i < 5; i++) begin
      deal(1'b1, tbl[i].seed, 1'b0);
      chk("tbl_roles2", r2_last, tbl[i].roles2);
      chk("tbl_lat2", lat2, tbl[i].lat2);
      if (i == 0) same_a = r1_last;
      if (i == 4) same_b = r1_last;
    end
    chk("same_seed_roles", same_a, same_b);

    repeat (3) @(posedge clock);
    #1;
    chk("valid_sticky", valid1, 1);
    chk("roles_sticky", roles1, r1_last);

    // start pulsed while busy must not disturb the deal in flight
    deal(1'b0, 16'h0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("no_second_deal", {busy1, busy2}, 0);

    // reset in PROBE clears outputs asynchronously
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_busy", {busy1, busy2}, 0);
    chk("midreset_valid", {valid1, valid2}, 0);
    chk("midreset_roles", {roles1, roles2}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    deal(1'b0, 16'h0, 1'b0);
    chk("post_reset_valid", {valid1, valid2}, 2'b11);

    retry_seen = 0;
    max_lat2 = 0;
    for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) seen[a][b] = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      deal($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 7) == 0);
      cnt = '{0, 0, 0, 0};
      wp = 0; dp = 0;
      for (int p = 0; p < 5; p++) begin
        f = r1_last[2*(4-p) +: 2];
        cnt[f]++;
        if (f == 2'b01) wp = p;
        if (f == 2'b10) dp = p;
      end
      chk("cnt_wolf", cnt[1], 1);
      chk("cnt_doctor", cnt[2], 1);
      chk("cnt_seer", cnt[3], NS1);
      chk("cnt_villager", cnt[0], 3 - NS1);
      seen[wp][dp] = 1;
      chk("n2_shape", (r2_last == 4'b0110) || (r2_last == 4'b1001), 1);
      if (lat2 > 6) retry_seen = 1;
      if (lat2 > max_lat2) max_lat2 = lat2;
    end
    covered = 0;
    for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) if (seen[a][b]) covered++;
    chk("pair_coverage", covered, 20);
    chk("n2_retry_seen", retry_seen, 1);
    chk("n2_max_lat_le8", max_lat2 <= 8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/role_dealer.md
Name: role_dealer

Overview:
- Parametrised successor to the fixed 20-entry role table used by the game controller.
- Deals a random role vector for N_PLAYERS players, with N_WOLVES wolves and N_DOCTORS doctors; every other player is a villager.
- Uses a free-running LFSR plus bounded linear probing, so every deal terminates in a known maximum number of cycles.
- Sits between the game FSM (start/ack) and the player-state registers that consume roles.

Parameters:
- N_PLAYERS, 5, number of players; 2..16.
- N_WOLVES, 1, wolves per deal; 1..N_PLAYERS-1.
- N_DOCTORS, 1, doctors per deal; 0..N_PLAYERS-N_WOLVES.
- LFSR_W, 16, LFSR width; fixed at 16 (taps below).

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- seed_load  in  1  loads seed_in into the LFSR this cycle.
- seed_in  in  16  LFSR seed; 0 is loaded as 0x0001.
- start  in  1  one-cycle request for a new deal; ignored while busy=1.
- busy  out  1  deal in progress.
- roles_valid  out  1  roles holds a completed deal.
- roles  out  2*N_PLAYERS  packed roles; player 0 in the MSB field. Encoding: 00 villager, 01 wolf, 10 doctor, 11 seer (seer only with the optional feature).

Behaviour:
- Reset values: busy=0, roles_valid=0, roles=0, LFSR=0x0001, state=IDLE.
- LFSR
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400).
  - Advances every cycle in every state, so request timing supplies entropy.
  - seed_load has priority over advance.
- Placement order: all wolves, then all doctors (then all seers). A role counter tracks remaining placements of the current kind.
- IDX_W = clog2(N_PLAYERS).
- States and transitions:
  - IDLE: start -> CLEAR; busy=1, roles_valid=0. roles keeps the old value until DONE.
  - CLEAR: working vector and occupancy mask cleared -> DRAW. Exactly 1 cycle.
  - DRAW: cand = LFSR[IDX_W-1:0]; if cand >= N_PLAYERS then cand = cand - N_PLAYERS. Register cand -> PROBE. 1 cycle.
  - PROBE:
    - Slot cand free: write the role, set the occupancy bit, decrement the counter. Go to DRAW if placements remain, else DONE.
    - Slot occupied: cand = cand+1, wrapping N_PLAYERS-1 -> 0; stay in PROBE.
  - DONE: roles <= working vector; roles_valid=1; busy=0 -> IDLE. roles_valid stays 1 until the next accepted start.
- Latency:
  - start accepted at edge t; busy visible from t+1.
  - Minimum to roles_valid: 1 + 2*P + 1 cycles, where P is total placements.
  - Maximum: 1 + P*(1+N_PLAYERS) + 1 cycles (probe bounded by N_PLAYERS-1 misses).
- Boundary conditions:
  - N_WOLVES+N_DOCTORS(+N_SEERS) = N_PLAYERS is legal: no villagers; probing still terminates.
  - start while busy: ignored, no effect.
  - start coincident with seed_load: both take effect; DRAW uses the new sequence.
  - Reset mid-deal: returns to reset values immediately; no partial vector is ever presented.
  - Illegal parameter combination: elaboration-time error (generate-time check); no runtime flag.

Optional Feature:
- Macro: ROLE_DEALER_SEER_EN.
- Defined:
  - Adds parameter N_SEERS (default 1), placed after the doctors with code 11.
  - Placement limit becomes N_WOLVES+N_DOCTORS+N_SEERS <= N_PLAYERS.
- Undefined:
  - Code 11 is never produced.
  - No N_SEERS parameter; logic is identical to the base design.

Decomposition:
- Shared package lobinho_pkg:
  - Role codes ROLE_VILLAGER, ROLE_WOLF, ROLE_DOCTOR, ROLE_SEER.
  - role_t 2-bit typedef.
  - LFSR_TAPS constant 0xB400.
  - Dealer state enum.
- One sub-module, lfsr16: clock, reset, load, seed, advance-every-cycle, zero-seed remap. It is reused by the vote/tie-break logic.

Test Plan:
- Reset: assert reset for 3 cycles -> busy=0, roles_valid=0, roles=10'b0. Release; 2 idle cycles -> outputs unchanged.
- Default params, seed_in=0x0001, start on the next cycle:
  - roles_valid within 12 cycles.
  - Exactly one 01 field, one 10 field, three 00 fields.
  - Value matches the bench reference model.
  - Repeat 1000 deals: each of the 20 (wolf, doctor) pairs occurs at least once.
- N_PLAYERS=2, N_WOLVES=1, N_DOCTORS=1:
  - Every deal yields roles = 4'b0110 or 4'b1001.
  - Probe path exercised: coverage shows at least one occupied-slot retry.
  - Deal completes in at most 8 cycles.
- seed_in=0x0000 load -> LFSR reads 0x0001 next cycle. Two deals with the same seed and the same start offset -> identical roles.
- Robustness:
  - start pulsed while busy -> ignored; single deal completes.
  - reset asserted mid-PROBE -> outputs return to 0 the same cycle.
  - Next start after reset -> valid deal.
- ROLE_DEALER_SEER_EN with N_PLAYERS=5, N_SEERS=1 -> exactly one each of 01, 10, 11 and two 00. Without the macro, 11 never appears over 1000 deals.
